// File: rtl/ofm_writeback.sv
// OFM writeback: captures accumulator rows, requantizes each lane (round, shift,
// leaky ReLU, saturate) and writes the packed row at a counter-derived OFM address.
module ofm_writeback #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int NO_FILTER     = 16,
  parameter int NO_TILE       = 4,
  parameter int ACC_W         = 32,
  parameter int OUT_W         = 16,
  parameter int ADDR_W        = 16,
  parameter int BASE_ADDR     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [4:0]                     shift,
  input  logic                           relu_en,
  input  logic                           write_out_en,
  input  logic [SYSTOLIC_SIZE*ACC_W-1:0] acc_in,
  output logic                           ofm_wr_en,
  output logic [ADDR_W-1:0]              ofm_wr_addr,
  output logic [SYSTOLIC_SIZE*OUT_W-1:0] ofm_wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overflow
);

  localparam int NO_FG  = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int ROW_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int TILE_W = (NO_TILE > 1) ? $clog2(NO_TILE) : 1;
  localparam int FG_W   = (NO_FG > 1) ? $clog2(NO_FG) : 1;
  localparam int S1_W   = ACC_W + 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SYSTOLIC_SIZE - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NO_TILE - 1);
  localparam logic [FG_W-1:0]   FG_LAST   = FG_W'(NO_FG - 1);

  localparam logic signed [S1_W-1:0] SAT_MAX = S1_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [S1_W-1:0] SAT_MIN = -(S1_W'(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0]       OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]       OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [TILE_W-1:0]   tile_reg, tile_next;
  logic [FG_W-1:0]     fg_reg, fg_next;
  logic [1:0]          flush_cnt_reg, flush_cnt_next;
  logic [4:0]          shift_reg, shift_next;
  logic                relu_reg, relu_next;
  logic                err_reg, err_next;
  logic                done_reg, done_next;
  logic                accept;

  logic [31:0]         filt_idx;
  logic [ADDR_W-1:0]   addr_next;
  logic                wr_ok;

  logic                               p0_wr_reg;
  logic [ADDR_W-1:0]                  p0_addr_reg;
  logic [SYSTOLIC_SIZE*ACC_W-1:0]     p0_acc_reg;
  logic                               p1_wr_reg;
  logic [ADDR_W-1:0]                  p1_addr_reg;
  logic [SYSTOLIC_SIZE*S1_W-1:0]      p1_val_reg;
  logic [SYSTOLIC_SIZE*S1_W-1:0]      s1_next;
  logic [SYSTOLIC_SIZE*OUT_W-1:0]     q_next;
  logic                               wr_en_reg;
  logic [ADDR_W-1:0]                  wr_addr_reg;
  logic [SYSTOLIC_SIZE*OUT_W-1:0]     wr_data_reg;
  logic signed [S1_W-1:0]             rnd;

  assign filt_idx  = 32'(fg_reg) * 32'(SYSTOLIC_SIZE) + 32'(row_reg);
  assign addr_next = ADDR_W'(32'(BASE_ADDR) + filt_idx * 32'(NO_TILE) + 32'(tile_reg));
  assign wr_ok     = filt_idx < 32'(NO_FILTER);

  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    tile_next      = tile_reg;
    fg_next        = fg_reg;
    flush_cnt_next = flush_cnt_reg;
    shift_next     = shift_reg;
    relu_next      = relu_reg;
    err_next       = err_reg;
    done_next      = 1'b0;
    accept         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          row_next   = '0;
          tile_next  = '0;
          fg_next    = '0;
          shift_next = shift;
          relu_next  = relu_en;
          err_next   = 1'b0;
        end
        // A beat arriving with start is still a stray beat.
        if (write_out_en) err_next = 1'b1;
      end
      RUN: begin
        if (write_out_en) begin
          accept = 1'b1;
          if (row_reg == ROW_LAST) begin
            row_next = '0;
            if (tile_reg == TILE_LAST) begin
              tile_next = '0;
              if (fg_reg == FG_LAST) begin
                fg_next        = '0;
                state_next     = FLUSH;
                flush_cnt_next = 2'd0;
              end else begin
                fg_next = fg_reg + FG_W'(1);
              end
            end else begin
              tile_next = tile_reg + TILE_W'(1);
            end
          end else begin
            row_next = row_reg + ROW_W'(1);
          end
        end
      end
      FLUSH: begin
        if (write_out_en) err_next = 1'b1;
        if (flush_cnt_reg == 2'd2) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          flush_cnt_next = flush_cnt_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      tile_reg      <= '0;
      fg_reg        <= '0;
      flush_cnt_reg <= '0;
      shift_reg     <= '0;
      relu_reg      <= 1'b0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      tile_reg      <= tile_next;
      fg_reg        <= fg_next;
      flush_cnt_reg <= flush_cnt_next;
      shift_reg     <= shift_next;
      relu_reg      <= relu_next;
      err_reg       <= err_next;
      done_reg      <= done_next;
    end
  end

  assign rnd = (shift_reg == 5'd0) ? '0 : (S1_W'(1) << (shift_reg - 5'd1));

  genvar gi;
  generate
    for (gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_lane
      logic signed [ACC_W-1:0] acc_lane;
      logic signed [S1_W-1:0]  sum;
      logic signed [S1_W-1:0]  v;
      logic signed [S1_W-1:0]  lk;
      assign acc_lane = p0_acc_reg[gi*ACC_W +: ACC_W];
      // One extra bit keeps the rounding add from wrapping at the positive limit.
      assign sum = S1_W'(acc_lane) + rnd;
      assign s1_next[gi*S1_W +: S1_W] = sum >>> shift_reg;
      assign v  = p1_val_reg[gi*S1_W +: S1_W];
      assign lk = (relu_reg && v[S1_W-1]) ? (v >>> 3) : v;
      assign q_next[gi*OUT_W +: OUT_W] = (lk > SAT_MAX) ? OUT_MAX :
                                         (lk < SAT_MIN) ? OUT_MIN : lk[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_wr_reg   <= 1'b0;
      p0_addr_reg <= '0;
      p0_acc_reg  <= '0;
      p1_wr_reg   <= 1'b0;
      p1_addr_reg <= '0;
      p1_val_reg  <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      p0_wr_reg   <= accept && wr_ok;
      p0_addr_reg <= addr_next;
      if (accept) p0_acc_reg <= acc_in;
      p1_wr_reg   <= p0_wr_reg;
      p1_addr_reg <= p0_addr_reg;
      p1_val_reg  <= s1_next;
      wr_en_reg   <= p1_wr_reg;
      wr_addr_reg <= p1_addr_reg;
      wr_data_reg <= q_next;
    end
  end

  assign ofm_wr_en    = wr_en_reg;
  assign ofm_wr_addr  = wr_addr_reg;
  assign ofm_wr_data  = wr_data_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign err_overflow = err_reg;

endmodule

// File: tb/tb_ofm_writeback.sv
// Bench for ofm_writeback: two instances (NO_FILTER 16 and 20) checked every cycle
// against a cycle-indexed expectation table built from the layer rules.
module tb_ofm_writeback;
  localparam int S = 16, AW = 32, OW = 16, MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, wen_a = 1'b0, start_b = 1'b0, wen_b = 1'b0;
  logic [4:0] shift = '0;
  logic relu_en = 1'b0;
  logic [S*AW-1:0] acc_in = '0;
  logic en_a, done_a, busy_a, err_a, en_b, done_b, busy_b, err_b;
  logic [15:0] addr_a, addr_b;
  logic [S*OW-1:0] data_a, data_b;

  ofm_writeback #(.NO_FILTER(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .shift(shift), .relu_en(relu_en),
    .write_out_en(wen_a), .acc_in(acc_in), .ofm_wr_en(en_a), .ofm_wr_addr(addr_a),
    .ofm_wr_data(data_a), .busy(busy_a), .done(done_a), .err_overflow(err_a));

  ofm_writeback #(.NO_FILTER(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .shift(shift), .relu_en(relu_en),
    .write_out_en(wen_b), .acc_in(acc_in), .ofm_wr_en(en_b), .ofm_wr_addr(addr_b),
    .ofm_wr_data(data_b), .busy(busy_b), .done(done_b), .err_overflow(err_b));

  always #5 clk = ~clk;

  // Expectations indexed by posedge count.
  bit              exp_vld  [2][MAXC];
  bit              exp_en   [2][MAXC];
  logic [15:0]     exp_addr [2][MAXC];
  logic [S*OW-1:0] exp_data [2][MAXC];
  bit              exp_done [2][MAXC];
  bit              exp_busy [2][MAXC];
  bit              exp_err  [2][MAXC];

  int phase [2] = '{0, 0};
  int beats [2] = '{0, 0};
  int done_cyc [2] = '{-1, -1};
  bit err_m [2] = '{0, 0};
  int shl [2] = '{0, 0};
  bit rel [2] = '{0, 0};
  int nof [2] = '{16, 20};
  int total [2] = '{64, 128};
  int wr_cnt [2] = '{0, 0};
  int max_addr [2] = '{0, 0};

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, expv);
  endtask

  function automatic logic [OW-1:0] rq(logic [AW-1:0] a, int sh, bit r);
    longint n, d, v, w;
    n = longint'($signed(a));
    d = longint'(1) << sh;
    if (sh > 0) n = n + d / 2;
    v = n / d;
    if ((n % d != 0) && (n < 0)) v = v - 1;
    if (r && v < 0) begin
      w = v / 8;
      if (v % 8 != 0) w = w - 1;
      v = w;
    end
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[OW-1:0];
  endfunction

  function automatic logic [S*AW-1:0] mk_acc(int idx);
    logic [S*AW-1:0] r;
    longint v;
    r = '0;
    for (int k = 0; k < S; k++) begin
      v = longint'(idx + 1) * longint'(k + 1) * 40503;
      if ((idx + k) % 3 == 0) v = -v;
      r[k*AW +: AW] = v[31:0];
    end
    return r;
  endfunction

  task automatic model(int m, bit r, bit st, bit we, logic [S*AW-1:0] a);
    int c1;
    int i, row, tile, fg, f;
    logic [S*OW-1:0] d;
    c1 = cyc + 1;
    if (!r) begin
      for (int c = c1; c < MAXC; c++) exp_en[m][c] = 1'b0;
      phase[m] = 0; beats[m] = 0; err_m[m] = 1'b0; done_cyc[m] = -1;
    end else if (phase[m] == 0) begin
      if (st) begin
        phase[m] = 1; beats[m] = 0; shl[m] = int'(shift); rel[m] = relu_en; err_m[m] = 1'b0;
      end
      if (we) err_m[m] = 1'b1;
    end else if (phase[m] == 1) begin
      if (we) begin
        i = beats[m];
        row = i % S; tile = (i / S) % 4; fg = i / (S * 4);
        f = fg * S + row;
        if (f < nof[m]) begin
          for (int k = 0; k < S; k++) d[k*OW +: OW] = rq(a[k*AW +: AW], shl[m], rel[m]);
          exp_en[m][cyc+3] = 1'b1;
          exp_addr[m][cyc+3] = 16'(f * 4 + tile);
          exp_data[m][cyc+3] = d;
        end
        beats[m]++;
        if (beats[m] == total[m]) begin
          phase[m] = 2;
          done_cyc[m] = cyc + 4;
        end
      end
    end else begin
      if (we) err_m[m] = 1'b1;
      if (c1 == done_cyc[m]) phase[m] = 0;
    end
    exp_vld[m][c1]  = 1'b1;
    exp_busy[m][c1] = (phase[m] != 0);
    exp_done[m][c1] = (c1 == done_cyc[m]);
    exp_err[m][c1]  = err_m[m];
  endtask

  task automatic step(bit r, bit sa, bit wa, bit sb, bit wb, logic [S*AW-1:0] a);
    rst_n = r; start_a = sa; wen_a = wa; start_b = sb; wen_b = wb; acc_in = a;
    model(0, r, sa, wa, a);
    model(1, r, sb, wb, a);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_layer(int m, int first, int n, int gap);
    for (int i = first; i < n; i++) begin
      step(1'b1, 1'b0, m == 0, 1'b0, m == 1, mk_acc(i));
      idle(gap);
    end
  endtask

  task automatic check_inst(int m, logic en, logic [15:0] ad, logic [S*OW-1:0] da,
                            logic dn, logic bs, logic er);
    if (cyc < MAXC && exp_vld[m][cyc]) begin
      chk($sformatf("wr_en%0d", m), en, exp_en[m][cyc]);
      if (exp_en[m][cyc]) begin
        chk($sformatf("wr_addr%0d", m), ad, exp_addr[m][cyc]);
        chk($sformatf("wr_data%0d", m), da, exp_data[m][cyc]);
      end
      chk($sformatf("done%0d", m), dn, exp_done[m][cyc]);
      chk($sformatf("busy%0d", m), bs, exp_busy[m][cyc]);
      chk($sformatf("err%0d", m), er, exp_err[m][cyc]);
    end
    if (en === 1'b1) begin
      wr_cnt[m]++;
      if (int'(ad) > max_addr[m]) max_addr[m] = int'(ad);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check_inst(0, en_a, addr_a, data_a, done_a, busy_a, err_a);
      check_inst(1, en_b, addr_b, data_b, done_b, busy_b, err_b);
    end
  end

  initial begin
    logic [S*AW-1:0] a;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(2);

    // Layer A1: plain requantization, start during RUN ignored.
    shift = 5'd4; relu_en = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    a = mk_acc(0);
    a[0 +: 32] = 32'd1000;
    a[32 +: 32] = 32'hFFFFFC18;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    idle(2);
    chk("rq_pos", data_a[0 +: 16], 16'd63);
    chk("rq_neg", data_a[16 +: 16], 16'hFFC2);
    chk("first_addr", addr_a, 16'd0);
    chk("first_en", en_a, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk_acc(1));
    run_layer(0, 2, 64, 0);
    idle(6);
    chk("a1_writes", wr_cnt[0], 64);
    chk("a1_max_addr", max_addr[0], 63);
    chk("a1_err", err_a, 1'b0);

    // Layer A2: saturation at shift 0.
    shift = 5'd0; relu_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    a = mk_acc(0);
    a[64 +: 32] = 32'h7FFFFFFF;
    a[96 +: 32] = 32'h80000000;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    idle(2);
    chk("sat_pos", data_a[32 +: 16], 16'h7FFF);
    chk("sat_neg", data_a[48 +: 16], 16'h8000);
    run_layer(0, 1, 64, 0);
    idle(6);

    // Stray beat in IDLE, then start clears the flag.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk_acc(5));
    chk("stray_err", err_a, 1'b1);
    chk("stray_nowr", en_a, 1'b0);

    // Layer A3: leaky ReLU with gapped beats, then a beat during flush.
    shift = 5'd4; relu_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("start_clr_err", err_a, 1'b0);
    a = mk_acc(0);
    a[0 +: 32] = 32'hFFFFFC18;
    a[32 +: 32] = 32'd1000;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    idle(2);
    chk("relu_neg", data_a[0 +: 16], 16'hFFF8);
    chk("relu_pos", data_a[16 +: 16], 16'd63);
    run_layer(0, 1, 64, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk_acc(3));
    idle(5);
    chk("flush_beat_err", err_a, 1'b1);

    // Layer B (NO_FILTER=20): start with a same-cycle beat, then 128 beats.
    shift = 5'd3; relu_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mk_acc(7));
    run_layer(1, 0, 128, 0);
    idle(6);
    chk("b_writes", wr_cnt[1], 80);
    chk("b_max_addr", max_addr[1], 79);

    // Reset mid-layer on A after 30 beats.
    shift = 5'd2; relu_en = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_layer(0, 0, 30, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_en", en_a, 1'b0);
    chk("rst_async_busy", busy_a, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk_acc(0));
    idle(2);
    chk("restart_en", en_a, 1'b1);
    chk("restart_addr", addr_a, 16'd0);
    run_layer(0, 1, 64, 0);
    idle(6);
    chk("a_total_writes", wr_cnt[0], 284);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
